// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maze_pkg
// Description : Shared move encodings, heading/state enums and heading helpers
//               for the parametrised maze explorer.
// Revision    : 1.0 - initial release
// ============================================================================
package maze_pkg;

    localparam logic [2:0] MV_STOP  = 3'd0;
    localparam logic [2:0] MV_FWD   = 3'd1;
    localparam logic [2:0] MV_LEFT  = 3'd2;
    localparam logic [2:0] MV_RIGHT = 3'd3;
    localparam logic [2:0] MV_UTURN = 3'd4;

    typedef enum logic [1:0] {
        HEAD_N = 2'd0,
        HEAD_E = 2'd1,
        HEAD_S = 2'd2,
        HEAD_W = 2'd3
    } head_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXPLORE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    function automatic head_t turn_left(input head_t h);
        logic [1:0] v;
        v = h - 2'd1;
        return head_t'(v);
    endfunction

    function automatic head_t turn_right(input head_t h);
        logic [1:0] v;
        v = h + 2'd1;
        return head_t'(v);
    endfunction

    function automatic head_t reverse(input head_t h);
        logic [1:0] v;
        v = h + 2'd2;
        return head_t'(v);
    endfunction

    // North is decreasing y, east is increasing x.
    function automatic logic signed [1:0] head_dx(input head_t h);
        case (h)
            HEAD_E:  return 2'sd1;
            HEAD_W:  return -2'sd1;
            default: return 2'sd0;
        endcase
    endfunction

    function automatic logic signed [1:0] head_dy(input head_t h);
        case (h)
            HEAD_N:  return -2'sd1;
            HEAD_S:  return 2'sd1;
            default: return 2'sd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/maze_explorer_param_if.sv
`default_nettype none
// ============================================================================
// Module      : maze_explorer_param_if
// Description : Sensor-in / move-out bundle between the wall-sensor front end,
//               the explorer and the motion controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface maze_explorer_param_if #(
    parameter int ROWS = 9,
    parameter int COLS = 9,
    parameter int DE_W = 8
);
    localparam int c_XW = $clog2(COLS);
    localparam int c_YW = $clog2(ROWS);

    logic            sense_valid;
    logic            left;
    logic            mid;
    logic            right;
    logic [2:0]      move;
    logic            move_valid;
    logic [c_XW-1:0] pos_x;
    logic [c_YW-1:0] pos_y;
    logic [1:0]      heading;
    logic [DE_W-1:0] deadend_cnt;
    logic            done;

    modport master (
        output sense_valid, left, mid, right,
        input  move, move_valid, pos_x, pos_y, heading, deadend_cnt, done
    );

    modport slave (
        input  sense_valid, left, mid, right,
        output move, move_valid, pos_x, pos_y, heading, deadend_cnt, done
    );
endinterface
`default_nettype wire

// File: rtl/maze_dir_select.sv
`default_nettype none
// ============================================================================
// Module      : maze_dir_select
// Description : Combinational left-hand-rule move chooser. Least-visited
//               tie-break enabled by MAZE_VISIT_TIEBREAK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module maze_dir_select #(
    parameter int CNT_W = 2
) (
    input  logic             i_wall_l,
    input  logic             i_wall_m,
    input  logic             i_wall_r,
    input  logic             i_in_l,
    input  logic             i_in_m,
    input  logic             i_in_r,
    input  logic [CNT_W-1:0] i_vis_l,
    input  logic [CNT_W-1:0] i_vis_m,
    input  logic [CNT_W-1:0] i_vis_r,
    input  maze_pkg::head_t  i_head,
    output logic [2:0]       o_move,
    output maze_pkg::head_t  o_head,
    output logic             o_dead_end
);
    import maze_pkg::*;

    logic w_open_l, w_open_m, w_open_r;
    logic w_pick_l, w_pick_m, w_pick_r;

    // An off-grid neighbour is a wall whatever the sensor reports.
    assign w_open_l = !i_wall_l && i_in_l;
    assign w_open_m = !i_wall_m && i_in_m;
    assign w_open_r = !i_wall_r && i_in_r;

`ifdef MAZE_VISIT_TIEBREAK_EN
    assign w_pick_l = w_open_l && (!w_open_m || (i_vis_l <= i_vis_m))
                               && (!w_open_r || (i_vis_l <= i_vis_r));
    assign w_pick_m = !w_pick_l && w_open_m && (!w_open_r || (i_vis_m <= i_vis_r));
    assign w_pick_r = !w_pick_l && !w_pick_m && w_open_r;
`else
    logic w_unused_vis;
    assign w_unused_vis = ^{i_vis_l, i_vis_m, i_vis_r};
    assign w_pick_l = w_open_l;
    assign w_pick_m = !w_open_l && w_open_m;
    assign w_pick_r = !w_open_l && !w_open_m && w_open_r;
`endif

    always_comb begin
        o_move     = MV_UTURN;
        o_head     = reverse(i_head);
        o_dead_end = 1'b0;
        if (w_pick_l) begin
            o_move = MV_LEFT;
            o_head = turn_left(i_head);
        end else if (w_pick_m) begin
            o_move = MV_FWD;
            o_head = i_head;
        end else if (w_pick_r) begin
            o_move = MV_RIGHT;
            o_head = turn_right(i_head);
        end else begin
            // Only a genuine three-wall cell counts, not grid-edge masking.
            o_dead_end = i_wall_l && i_wall_m && i_wall_r;
        end
    end

endmodule
`default_nettype wire

// File: rtl/maze_explorer_param.sv
`default_nettype none
// ============================================================================
// Module      : maze_explorer_param
// Description : Pose tracker and move issuer for a ROWS x COLS maze bot with
//               visit and dead-end counters. Optional MAZE_VISIT_TIEBREAK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module maze_explorer_param #(
    parameter int ROWS       = 9,
    parameter int COLS       = 9,
    parameter int START_X    = 4,
    parameter int START_Y    = 8,
    parameter int START_HEAD = 0,
    parameter int EXIT_X     = 4,
    parameter int EXIT_Y     = 0,
    parameter int CNT_W      = 2,
    parameter int DE_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    maze_explorer_param_if.slave bus
);
    import maze_pkg::*;

    localparam int c_XW        = $clog2(COLS);
    localparam int c_YW        = $clog2(ROWS);
    localparam int c_CELLS     = ROWS * COLS;
    localparam int c_IW        = $clog2(c_CELLS);
    localparam int c_START_IDX = START_Y * COLS + START_X;

    localparam logic [c_XW-1:0]  c_X_LAST     = c_XW'(COLS - 1);
    localparam logic [c_YW-1:0]  c_Y_LAST     = c_YW'(ROWS - 1);
    localparam logic [c_XW-1:0]  c_START_X    = c_XW'(START_X);
    localparam logic [c_YW-1:0]  c_START_Y    = c_YW'(START_Y);
    localparam logic [c_XW-1:0]  c_EXIT_X     = c_XW'(EXIT_X);
    localparam logic [c_YW-1:0]  c_EXIT_Y     = c_YW'(EXIT_Y);
    localparam head_t            c_START_HEAD = head_t'(2'(START_HEAD));
    localparam logic [CNT_W-1:0] c_CNT_MAX    = '1;
    localparam logic [DE_W-1:0]  c_DE_MAX     = '1;

    function automatic logic f_in_grid(input logic [c_XW-1:0] x,
                                       input logic [c_YW-1:0] y,
                                       input head_t h);
        case (h)
            HEAD_N:  return y != '0;
            HEAD_E:  return x != c_X_LAST;
            HEAD_S:  return y != c_Y_LAST;
            default: return x != '0;
        endcase
    endfunction

    function automatic logic [c_XW-1:0] f_step_x(input logic [c_XW-1:0] x, input head_t h);
        logic [c_XW-1:0] d;
        d = c_XW'(head_dx(h));
        return x + d;
    endfunction

    function automatic logic [c_YW-1:0] f_step_y(input logic [c_YW-1:0] y, input head_t h);
        logic [c_YW-1:0] d;
        d = c_YW'(head_dy(h));
        return y + d;
    endfunction

    function automatic logic [c_IW-1:0] f_idx(input logic [c_XW-1:0] x, input logic [c_YW-1:0] y);
        int idx;
        idx = int'(y) * COLS + int'(x);
        return c_IW'(idx);
    endfunction

    state_t           r_state, w_state_nxt;
    logic [c_XW-1:0]  r_x;
    logic [c_YW-1:0]  r_y;
    head_t            r_head;
    logic [2:0]       r_move;
    logic             r_move_valid;
    logic [DE_W-1:0]  r_dc;
    logic             r_done;
    logic [CNT_W-1:0] r_visit [c_CELLS];

    head_t            w_side_head [3];
    logic             w_side_in   [3];
    logic [CNT_W-1:0] w_side_vis  [3];

    logic [2:0]       w_sel_move, w_move_nxt;
    head_t            w_sel_head, w_head_nxt;
    logic             w_sel_de, w_mv_nxt;
    logic             w_turn, w_commit, w_at_exit;
    logic [c_XW-1:0]  w_dest_x;
    logic [c_YW-1:0]  w_dest_y;
    logic [c_IW-1:0]  w_dest_idx;

    // Side order 0/1/2 = left/mid/right relative to the current heading.
    assign w_side_head[0] = turn_left(r_head);
    assign w_side_head[1] = r_head;
    assign w_side_head[2] = turn_right(r_head);

    for (genvar i = 0; i < 3; i++) begin : g_side
        assign w_side_in[i]  = f_in_grid(r_x, r_y, w_side_head[i]);
        assign w_side_vis[i] = w_side_in[i]
            ? r_visit[f_idx(f_step_x(r_x, w_side_head[i]), f_step_y(r_y, w_side_head[i]))]
            : '0;
    end

    maze_dir_select #(
        .CNT_W (CNT_W)
    ) u_dir_select (
        .i_wall_l   (bus.left),
        .i_wall_m   (bus.mid),
        .i_wall_r   (bus.right),
        .i_in_l     (w_side_in[0]),
        .i_in_m     (w_side_in[1]),
        .i_in_r     (w_side_in[2]),
        .i_vis_l    (w_side_vis[0]),
        .i_vis_m    (w_side_vis[1]),
        .i_vis_r    (w_side_vis[2]),
        .i_head     (r_head),
        .o_move     (w_sel_move),
        .o_head     (w_sel_head),
        .o_dead_end (w_sel_de)
    );

    // Every committed move advances one cell along the (possibly new) heading.
    assign w_turn     = (r_state == ST_EXPLORE) && bus.sense_valid;
    assign w_commit   = (r_state == ST_IDLE) || w_turn;
    assign w_head_nxt = w_turn ? w_sel_head : r_head;
    assign w_dest_x   = f_step_x(r_x, w_head_nxt);
    assign w_dest_y   = f_step_y(r_y, w_head_nxt);
    assign w_dest_idx = f_idx(w_dest_x, w_dest_y);
    assign w_at_exit  = (w_dest_x == c_EXIT_X) && (w_dest_y == c_EXIT_Y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_move_nxt  = MV_STOP;
        w_mv_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_move_nxt  = MV_FWD;
                w_mv_nxt    = 1'b1;
                w_state_nxt = ST_EXPLORE;
            end
            ST_EXPLORE: begin
                if (bus.sense_valid) begin
                    w_move_nxt = w_sel_move;
                    w_mv_nxt   = 1'b1;
                end
            end
            default: ;
        endcase
        if (w_commit && w_at_exit) begin
            w_state_nxt = ST_DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x          <= c_START_X;
            r_y          <= c_START_Y;
            r_head       <= c_START_HEAD;
            r_move       <= MV_STOP;
            r_move_valid <= 1'b0;
            r_dc         <= '0;
            r_done       <= 1'b0;
        end else begin
            r_move       <= w_move_nxt;
            r_move_valid <= w_mv_nxt;
            r_done       <= r_done || (w_state_nxt == ST_DONE);
            if (w_commit) begin
                r_x    <= w_dest_x;
                r_y    <= w_dest_y;
                r_head <= w_head_nxt;
            end
            if (w_turn && w_sel_de && (r_dc != c_DE_MAX)) begin
                r_dc <= r_dc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_CELLS; i++) begin
                r_visit[i] <= (i == c_START_IDX) ? CNT_W'(1) : '0;
            end
        end else if (w_commit && (r_visit[w_dest_idx] != c_CNT_MAX)) begin
            r_visit[w_dest_idx] <= r_visit[w_dest_idx] + 1'b1;
        end
    end

    assign bus.move        = r_move;
    assign bus.move_valid  = r_move_valid;
    assign bus.pos_x       = r_x;
    assign bus.pos_y       = r_y;
    assign bus.heading     = r_head;
    assign bus.deadend_cnt = r_dc;
    assign bus.done        = r_done;

endmodule
`default_nettype wire
